// File: rtl/adau1761_init_sequencer.sv
// Boot-time ADAU1761 register-write sequencer feeding an I2C controller command port.
// Optional feature: define INIT_RETRY_EN to retry NACKed writes up to MAX_RETRY times.
module adau1761_init_sequencer #(
  parameter int unsigned POWERUP_DELAY_CYC = 1_000_000,
  parameter int unsigned GAP_CYC           = 100,
  parameter logic [6:0]  DEV_ADDR          = 7'h3B
`ifdef INIT_RETRY_EN
  ,
  parameter int unsigned MAX_RETRY         = 3
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [6:0]  cmd_dev_addr,
  output logic [15:0] cmd_reg_addr,
  output logic [7:0]  cmd_data,
  input  logic        xfer_done,
  input  logic        xfer_nack,
  output logic        init_done,
  output logic        init_error,
  output logic [3:0]  err_index
);

  localparam int unsigned CNT_W   = 20;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned REG_W   = 16;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned RETRY_W = 2;

  localparam logic [CNT_W-1:0] PU_LAST  = CNT_W'(POWERUP_DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(10);

  typedef enum logic [2:0] {
    S_POWERUP,
    S_ISSUE,
    S_WAIT_DONE,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                  state, state_n;
  logic [IDX_W-1:0]        index, index_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic                    cmd_valid_n;
  logic [REG_W-1:0]        cmd_reg_addr_n;
  logic [DATA_W-1:0]       cmd_data_n;
  logic                    init_done_n, init_error_n;
  logic [IDX_W-1:0]        err_index_n;
  logic                    load;
  logic                    reissue;

`ifdef INIT_RETRY_EN
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
  logic [RETRY_W-1:0] retry, retry_n;
  // A non-zero retry count on leaving Gap means the last attempt was NACKed.
  assign reissue = (retry != '0);
`else
  assign reissue = 1'b0;
`endif

  // Fixed boot table: {register address, data}.
  function automatic logic [REG_W+DATA_W-1:0] table_entry(input logic [IDX_W-1:0] idx);
    case (idx)
      4'd0:    return {16'h4000, 8'h01};
      4'd1:    return {16'h4015, 8'h01};
      4'd2:    return {16'h400A, 8'h01};
      4'd3:    return {16'h400C, 8'h01};
      4'd4:    return {16'h4019, 8'h13};
      4'd5:    return {16'h401C, 8'h21};
      4'd6:    return {16'h401E, 8'h41};
      4'd7:    return {16'h4029, 8'h03};
      4'd8:    return {16'h402A, 8'h03};
      4'd9:    return {16'h40F9, 8'h7F};
      4'd10:   return {16'h40FA, 8'h03};
      default: return '0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_POWERUP;
      index        <= '0;
      cnt          <= '0;
      cmd_valid    <= 1'b0;
      cmd_dev_addr <= DEV_ADDR;
      cmd_reg_addr <= '0;
      cmd_data     <= '0;
      init_done    <= 1'b0;
      init_error   <= 1'b0;
      err_index    <= '0;
`ifdef INIT_RETRY_EN
      retry        <= '0;
`endif
    end else begin
      state        <= state_n;
      index        <= index_n;
      cnt          <= cnt_n;
      cmd_valid    <= cmd_valid_n;
      cmd_dev_addr <= DEV_ADDR;
      cmd_reg_addr <= cmd_reg_addr_n;
      cmd_data     <= cmd_data_n;
      init_done    <= init_done_n;
      init_error   <= init_error_n;
      err_index    <= err_index_n;
`ifdef INIT_RETRY_EN
      retry        <= retry_n;
`endif
    end
  end

  always_comb begin
    state_n        = state;
    index_n        = index;
    cnt_n          = cnt;
    cmd_valid_n    = cmd_valid;
    cmd_reg_addr_n = cmd_reg_addr;
    cmd_data_n     = cmd_data;
    init_done_n    = init_done;
    init_error_n   = init_error;
    err_index_n    = err_index;
    load           = 1'b0;
`ifdef INIT_RETRY_EN
    retry_n        = retry;
`endif

    case (state)
      S_POWERUP: begin
        if (cnt == PU_LAST) begin
          state_n = S_ISSUE;
          cnt_n   = '0;
          index_n = '0;
          load    = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      // Address/data were loaded on entry; valid rises one cycle later.
      S_ISSUE: begin
        if (!cmd_valid) begin
          cmd_valid_n = 1'b1;
        end else if (cmd_ready) begin
          cmd_valid_n = 1'b0;
          state_n     = S_WAIT_DONE;
        end
      end

      S_WAIT_DONE: begin
        if (xfer_done) begin
          if (!xfer_nack) begin
            state_n = S_GAP;
            cnt_n   = '0;
`ifdef INIT_RETRY_EN
            retry_n = '0;
`endif
          end else begin
`ifdef INIT_RETRY_EN
            if (retry < RETRY_LIMIT) begin
              retry_n = retry + RETRY_W'(1);
              state_n = S_GAP;
              cnt_n   = '0;
            end else begin
              state_n      = S_ERROR;
              init_error_n = 1'b1;
              err_index_n  = index;
            end
`else
            state_n      = S_ERROR;
            init_error_n = 1'b1;
            err_index_n  = index;
`endif
          end
        end
      end

      S_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_n = '0;
          if (reissue) begin
            state_n = S_ISSUE;
            load    = 1'b1;
          end else if (index == LAST_IDX) begin
            state_n     = S_DONE;
            init_done_n = 1'b1;
          end else begin
            index_n = index + IDX_W'(1);
            state_n = S_ISSUE;
            load    = 1'b1;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      S_DONE, S_ERROR: begin
        if (start) begin
          state_n      = S_ISSUE;
          index_n      = '0;
          cnt_n        = '0;
          init_done_n  = 1'b0;
          init_error_n = 1'b0;
          err_index_n  = '0;
          load         = 1'b1;
`ifdef INIT_RETRY_EN
          retry_n      = '0;
`endif
        end
      end

      default: state_n = S_POWERUP;
    endcase

    if (load) begin
      {cmd_reg_addr_n, cmd_data_n} = table_entry(index_n);
    end
  end

endmodule
